// File: rtl/dsp_result_drain.sv
// Output drain for the DSP48A1 P/CARRYOUTF pipeline: a credit-gated result FIFO with valid/ready egress.
// Optional sticky protocol error output enabled by defining DSP_DRAIN_ERR_EN.
module dsp_result_drain #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             issue_ready,
  input  logic             p_valid,
  input  logic [WIDTH-1:0] p_in,
  input  logic             carry_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_carry
`ifdef DSP_DRAIN_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]  r_inflight;
  logic [CW-1:0]  r_occ;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [WIDTH:0] r_mem [DEPTH];
  logic [WIDTH:0] r_hold;

  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_issue_acc;
  logic [CW:0]    w_credit_sum;

  assign w_full       = (r_occ == CW'(DEPTH));
  assign m_valid      = (r_occ != '0);
  assign w_pop        = m_valid && m_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push       = p_valid && (!w_full || w_pop);
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_occ};
  assign issue_ready  = rst && (w_credit_sum < (CW+1)'(DEPTH));
  assign w_issue_acc  = issue && issue_ready;

  // r_hold tracks the head so the outputs keep the last head once the FIFO empties.
  assign {m_carry, m_data} = m_valid ? r_mem[r_rd_ptr] : r_hold;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {carry_in, p_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (m_valid) begin
        r_hold <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A result with nothing in flight is still buffered, but never drives the count below zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
    end else if (w_issue_acc && !p_valid) begin
      r_inflight <= r_inflight + CW'(1);
    end else if (!w_issue_acc && p_valid && (r_inflight != '0)) begin
      r_inflight <= r_inflight - CW'(1);
    end
  end

`ifdef DSP_DRAIN_ERR_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = (issue && !issue_ready)
                   || (p_valid && (r_inflight == '0))
                   || (p_valid && w_full && !w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_dsp_result_drain.sv
// Bench for dsp_result_drain: directed scenarios plus random traffic checked against a queue-based model.
// Define DSP_DRAIN_ERR_EN for both files to exercise the sticky error output.
module tb_dsp_result_drain;
  localparam int WIDTH = 48;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             issue;
  logic             issue_ready;
  logic             p_valid;
  logic [WIDTH-1:0] p_in;
  logic             carry_in;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_carry;
`ifdef DSP_DRAIN_ERR_EN
  logic             err;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a queue of {carry, data}, an in-flight count and a sticky error flag.
  logic [WIDTH:0] q[$];
  int             infl;
  logic [WIDTH:0] last;
  logic           m_err;
  logic [WIDTH-1:0] got[$];

  dsp_result_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .issue(issue),
    .issue_ready(issue_ready),
    .p_valid(p_valid),
    .p_in(p_in),
    .carry_in(carry_in),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_carry(m_carry)
`ifdef DSP_DRAIN_ERR_EN
    ,
    .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    infl  = 0;
    last  = '0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit rdy, acc, pop, full, push;
    rdy  = (infl + q.size()) < DEPTH;
    acc  = issue && rdy;
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && m_ready;
    push = p_valid && (!full || pop);
    if (issue && !rdy) m_err = 1'b1;
    if (p_valid && infl == 0) m_err = 1'b1;
    if (p_valid && full && !pop) m_err = 1'b1;
    if (q.size() != 0) last = q[0];
    if (pop) void'(q.pop_front());
    if (push) q.push_back({carry_in, p_in});
    if (acc && !p_valid) infl++;
    else if (!acc && p_valid && infl > 0) infl--;
  endtask

  task automatic step(input logic iss, input logic pv, input logic [WIDTH-1:0] d,
                      input logic c, input logic mr);
    issue = iss; p_valid = pv; p_in = d; carry_in = c; m_ready = mr;
    if (m_valid && m_ready) got.push_back(m_data);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    issue = 0; p_valid = 0; m_ready = 0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    issue = 0; p_valid = 0; p_in = '0; carry_in = 0; m_ready = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    vectors++; if (m_carry !== 1'b0) begin miscompares++; $display("FAIL reset_m_carry: got %0b want 0", m_carry); end
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL reset_issue_ready: got %0b want 0", issue_ready); end
`ifdef DSP_DRAIN_ERR_EN
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b want 0", err); end
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL release_issue_ready: got %0b want 1", issue_ready); end
  endtask

  task automatic test_single();
    step(1, 0, '0, 0, 1);
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_after_issue: got %0b want 1", issue_ready); end
    step(0, 1, 48'h0000_0000_1234, 1, 1);
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_m_valid: got %0b want 1", m_valid); end
    vectors++; if (m_data !== 48'h1234) begin miscompares++; $display("FAIL single_m_data: got %h want 1234", m_data); end
    vectors++; if (m_carry !== 1'b1) begin miscompares++; $display("FAIL single_m_carry: got %0b want 1", m_carry); end
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %0b want 1", issue_ready); end
    step(0, 0, '0, 0, 1);
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_m_valid_drop: got %0b want 0", m_valid); end
    vectors++; if (m_data !== 48'h1234) begin miscompares++; $display("FAIL single_hold_data: got %h want 1234", m_data); end
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_end: got %0b want 1", issue_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) step(1, 0, '0, 0, 0);
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_low: got %0b want 0", issue_ready); end
    for (int k = 1; k <= DEPTH; k++) step(0, 1, WIDTH'(k), 0, 0);
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL fill_m_valid: got %0b want 1", m_valid); end
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_full: got %0b want 0", issue_ready); end
    for (int k = 1; k <= DEPTH; k++) begin
      vectors++; if (m_data !== WIDTH'(k)) begin miscompares++; $display("FAIL fill_drain_order: got %0d want %0d", m_data, k); end
      step(0, 0, '0, 0, 1);
      if (k == 1) begin
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL fill_credit_return: got %0b want 1", issue_ready); end
      end
    end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL fill_empty: got %0b want 0", m_valid); end
  endtask

  task automatic test_blocked_issue();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, '0, 0, 0);
`ifdef DSP_DRAIN_ERR_EN
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL blocked_err_clear: got %0b want 0", err); end
`endif
    step(1, 0, '0, 0, 0);
`ifdef DSP_DRAIN_ERR_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL blocked_err_set: got %0b want 1", err); end
`endif
    step(1, 0, '0, 0, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 1, WIDTH'(48'hA0 + k), 0, 0);
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL blocked_ready: got %0b want 0", issue_ready); end
    for (int k = 0; k < DEPTH; k++) begin
      vectors++; if (m_data !== WIDTH'(48'hA0 + k)) begin miscompares++; $display("FAIL blocked_contents: got %h want %h", m_data, 48'hA0 + k); end
      step(0, 0, '0, 0, 1);
      if (k == 0) begin
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL blocked_no_extra_credit: got %0b want 1", issue_ready); end
      end
    end
`ifdef DSP_DRAIN_ERR_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL blocked_err_sticky: got %0b want 1", err); end
    do_reset();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL blocked_err_reset: got %0b want 0", err); end
`endif
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) step(1, 0, '0, 0, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 1, WIDTH'(11 + k), 0, 0);
    step(0, 1, WIDTH'(15), 1, 1);
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL fpp_still_full: got %0b want 0", issue_ready); end
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL fpp_m_valid: got %0b want 1", m_valid); end
    for (int k = 12; k <= 15; k++) begin
      vectors++; if (m_data !== WIDTH'(k)) begin miscompares++; $display("FAIL fpp_order: got %0d want %0d", m_data, k); end
      step(0, 0, '0, 0, 1);
    end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL fpp_empty: got %0b want 0", m_valid); end
    vectors++; if (m_carry !== 1'b1) begin miscompares++; $display("FAIL fpp_last_carry: got %0b want 1", m_carry); end
  endtask

  task automatic test_wrap();
    int issued, results, cyc;
    bit rdy, iss, pv;
    do_reset();
    got.delete();
    issued = 0; results = 0; cyc = 0;
    while (got.size() < 10 && cyc < 200) begin
      rdy = (infl + q.size()) < DEPTH;
      iss = (issued < 10) && rdy;
      pv  = (infl > 0);
      if (iss) issued++;
      if (pv) results++;
      step(iss, pv, WIDTH'(pv ? results : 0), 1'(results & 1), (cyc % 2) == 0);
      vectors++;
      if (m_valid !== (q.size() != 0) || issue_ready !== ((infl + q.size()) < DEPTH)) begin
        miscompares++;
        $display("FAIL wrap_cycle %0d: valid %0b ready %0b want valid %0b ready %0b", cyc, m_valid, issue_ready, q.size() != 0, (infl + q.size()) < DEPTH);
      end
      cyc++;
    end
    vectors++; if (got.size() != 10) begin miscompares++; $display("FAIL wrap_count: got %0d want 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== WIDTH'(i + 1)) begin miscompares++; $display("FAIL wrap_order[%0d]: got %0d want %0d", i, got[i], i + 1); end
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [WIDTH:0] exp_pkt;
    bit exp_v, pv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r  = {$urandom, $urandom};
      pv = (infl > 0 && ($urandom % 3) != 0) || (($urandom % 25) == 0);
      step(1'($urandom % 2), pv, r[WIDTH-1:0], 1'($urandom % 2), ($urandom % 3) != 0);
      exp_v   = (q.size() != 0);
      exp_pkt = exp_v ? q[0] : last;
      vectors++;
      if (m_valid !== exp_v || {m_carry, m_data} !== exp_pkt || issue_ready !== ((infl + q.size()) < DEPTH)) begin
        miscompares++;
        $display("FAIL random_cycle %0d: valid %0b head %h ready %0b want valid %0b head %h ready %0b",
                 c, m_valid, {m_carry, m_data}, issue_ready, exp_v, exp_pkt, (infl + q.size()) < DEPTH);
      end
`ifdef DSP_DRAIN_ERR_EN
      vectors++; if (err !== m_err) begin miscompares++; $display("FAIL random_err %0d: got %0b want %0b", c, err, m_err); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, WIDTH'(48'h5A5A_0000_0000 + k), 1, 0);
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %0b want 1", m_valid); end
    issue = 0; p_valid = 0; m_ready = 0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_m_valid: got %0b want 0", m_valid); end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL mid_m_data: got %h want 0", m_data); end
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL mid_issue_ready: got %0b want 0", issue_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: got %0b want 1", issue_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_release_valid: got %0b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_blocked_issue();
    test_full_push_pop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_result_drain.md
# dsp_result_drain

Output-side drain for the DSP48A1 slice datapath. Collects results leaving the non-stallable P/CARRYOUTF pipeline into a small FIFO and presents them downstream over a valid/ready handshake. Throttles the operand issuer with a credit check, so every in-flight operation has a guaranteed slot and no result is lost under downstream backpressure.

## Interface
- `WIDTH`, 48: result width (P bus).
- `DEPTH`, 4: FIFO entries, and also the maximum number of in-flight plus buffered results. Power of two, 2..16.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low. Assertion clears all state immediately; release is synchronous to `clk`.
- `issue` input 1: issuer launches one operation into the DSP pipeline this cycle.
- `issue_ready` output 1: credit available; `issue` is accepted only when this is high.
- `p_valid` input 1: a result is present on `p_in`/`carry_in` this cycle.
- `p_in` input WIDTH: result data (P).
- `carry_in` input 1: result carry (CARRYOUTF).
- `m_valid` output 1: head entry valid.
- `m_ready` input 1: downstream accepts the head entry.
- `m_data` output WIDTH: head data.
- `m_carry` output 1: head carry.
- `err` output 1: sticky protocol error, present only when the configuration macro is defined.

## Operation
- Counters:
  - `inflight` (0..DEPTH): +1 on accepted issue (`issue && issue_ready`); -1 on `p_valid`; unchanged when both occur.
  - `occ` (0..DEPTH): +1 on push (`p_valid`); -1 on pop (`m_valid && m_ready`); unchanged when both occur.
- `issue_ready = (inflight + occ) < DEPTH`, computed combinationally from registered counters. Forced 0 while `rst` is low.
- FIFO:
  - Circular buffer with wrapping rd/wr pointers of log2(DEPTH) bits.
  - `m_data`/`m_carry` are read from the head entry. They hold the last head value when `m_valid` is 0.
  - Data is stored verbatim, with no width change or sign handling.
- Full with push and pop in the same cycle: both succeed, `occ` stays DEPTH, no error.
- Empty with push: the entry is visible on the next cycle. There is no same-cycle bypass.
- `issue` while `issue_ready` is 0: ignored, and no counter changes.
- `p_valid` with `inflight` 0: data is still pushed if space exists, and `inflight` is held at 0 (no underflow).
- `p_valid` when full without a pop: data is dropped and the FIFO is unchanged.

## Timing
- Reset values: `m_valid` 0, `m_data` 0, `m_carry` 0, `err` 0, `issue_ready` 0. All counters and pointers are 0.
- First cycle after reset release: `issue_ready` is 1.
- Push-to-`m_valid` latency: 1 cycle. A result written at edge N gives `m_valid` = 1 after edge N.
- Throughput: 1 push and 1 pop per cycle.
- `issue_ready` drops in the same cycle the counters reach DEPTH. A credit freed by a pop at edge N is visible after edge N.
- Reset asserted mid-operation: all buffered and in-flight accounting is discarded immediately. Results that arrive later are treated as stray (see `err`).

## Configuration
- Macro: `DSP_DRAIN_ERR_EN`.
- Defined:
  - `err` port exists.
  - `err` sets on any of: `issue` while `issue_ready` is 0; `p_valid` with `inflight` 0; `p_valid` when full without a pop.
  - `err` clears only on reset.
- Undefined:
  - `err` port and its logic are absent.
  - The same three conditions are still handled silently as described under Operation.

## Test plan
- Reset release, then 1 issue and `p_valid` with `p_in`=48'h0000_0000_1234, `carry_in`=1, `m_ready`=1:
  - `m_valid` 1 for one cycle, `m_data`=48'h1234, `m_carry`=1.
  - `issue_ready` stays 1.
- DEPTH=4, `m_ready`=0, 4 issues on back-to-back cycles:
  - `issue_ready` goes 0 after the 4th.
  - 4 results (values 1..4) fill the FIFO.
  - Raising `m_ready` drains 1,2,3,4 in order, and `issue_ready` returns to 1 after the first pop.
- FIFO full, `p_valid` and `m_ready` in the same cycle (legal credit case via a stray push):
  - Pop and push both happen, order is preserved, `occ` stays 4.
- Wrap-around: 10 issue/result pairs with `m_ready` toggling 1,0,1,0:
  - All 10 values are delivered in order with none lost.
- Macro defined, `issue` held while `issue_ready` is 0:
  - `err` goes 1 the next cycle and stays 1 until `rst` is low.
  - Repeat with the macro undefined: no `err` port, and FIFO contents are unchanged.
- `rst` pulled low with 3 entries buffered:
  - `m_valid`, `m_data` and `issue_ready` go 0 immediately, without a clock edge.
  - After release, `issue_ready` is 1 and `m_valid` is 0.
